seg7_scan: RTL and testbench

Time-multiplexed driver for the 4-digit seven-segment display. It holds four hex digits plus a per-digit blank mask and scans them onto the shared segment bus and the four digit enables. Scan timing comes from an internal counter; no external select is needed. Combinational min/max/select logic upstream delivers the nibbles, and this block replaces hand-driven digit selects with a real refresh scan.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_hex_dec.sv | 11 +
 rtl/seg7_scan.sv | 113 +++++++++++
 tb/tb_seg7_scan.sv | 136 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - scan state type and hex-to-segment table for seg7_scan
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Segment bits are {g,f,e,d,c,b,a}, active-high; entry n is the glyph for hex n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// rtl/seg7_hex_dec.sv - combinational hex nibble to seven-segment decoder
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit multiplexed seven-segment scanner with frame-aligned updates
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  mask,
    input  logic        load,
    output logic [6:0]  d7seg,
    output logic        dig1,
    output logic        dig2,
    output logic        dig3,
    output logic        dig4,
    output logic        frame,
    output logic        upd_pending
);

    localparam int MAX_CYC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    scan_state_e  state_q;
    logic [1:0]   idx_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]  shadow_val_q;
    logic [3:0]   shadow_mask_q;
    logic [15:0]  pend_val_q;
    logic [3:0]   pend_mask_q;
    logic         pend_flag_q;
    logic         first_q;
    logic         frame_q;

    logic         show_end;
    logic         blank_end;
    logic         boundary;
    logic [6:0]   dec_seg;

    assign show_end  = (state_q == ST_SHOW)  && (cnt_q == SHOW_LAST);
    assign blank_end = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    // Updates only land between frames, plus once at the very first scan after reset.
    assign boundary  = (show_end && (idx_q == 2'd3)) || (blank_end && first_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            shadow_val_q  <= 16'd0;
            shadow_mask_q <= 4'b1111;
            pend_val_q    <= 16'd0;
            pend_mask_q   <= 4'd0;
            pend_flag_q   <= 1'b0;
            first_q       <= 1'b1;
            frame_q       <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            case (state_q)
                ST_BLANK: begin
                    if (blank_end) begin
                        state_q <= ST_SHOW;
                        cnt_q   <= '0;
                        first_q <= 1'b0;
                        frame_q <= (idx_q == 2'd0);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (show_end) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 2'd1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
            endcase

            if (boundary && pend_flag_q) begin
                shadow_val_q  <= pend_val_q;
                shadow_mask_q <= pend_mask_q;
            end

            // A load on the applying edge overwrites pending and keeps the flag set.
            if (load) begin
                pend_val_q  <= value;
                pend_mask_q <= mask;
                pend_flag_q <= 1'b1;
            end else if (boundary && pend_flag_q) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

    seg7_hex_dec u_dec (
        .nibble_i (shadow_val_q[{idx_q, 2'b00} +: 4]),
        .seg_o    (dec_seg)
    );

    assign d7seg       = ((state_q == ST_SHOW) && !shadow_mask_q[idx_q]) ? dec_seg : 7'd0;
    assign dig1        = (state_q == ST_SHOW) && (idx_q == 2'd0);
    assign dig2        = (state_q == ST_SHOW) && (idx_q == 2'd1);
    assign dig3        = (state_q == ST_SHOW) && (idx_q == 2'd2);
    assign dig4        = (state_q == ST_SHOW) && (idx_q == 2'd3);
    assign frame       = frame_q;
    assign upd_pending = pend_flag_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan (SHOW_CYC=4, BLANK_CYC=1)
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'd0;
    logic [3:0]  mask = 4'd0;
    logic        load = 1'b0;
    logic [6:0]  d7seg;
    logic        dig1, dig2, dig3, dig4;
    logic        frame;
    logic        upd_pending;

    int n_checks = 0;
    int n_errors = 0;
    logic pend_m = 1'b0;

    seg7_scan #(.SHOW_CYC(4), .BLANK_CYC(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .mask        (mask),
        .load        (load),
        .d7seg       (d7seg),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .dig4        (dig4),
        .frame       (frame),
        .upd_pending (upd_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Walks one 20-cycle frame from its frame-pulse cycle; up to two loads at chosen cycles.
    task automatic check_frame(input string tag,
                               input logic [6:0] s1, input logic [6:0] s2,
                               input logic [6:0] s3, input logic [6:0] s4,
                               input int ld_j, input logic [15:0] lv, input logic [3:0] lm,
                               input int ld2_j, input logic [15:0] lv2, input logic [3:0] lm2);
        logic [6:0] segs [4];
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        logic       apply;
        segs[0] = s1; segs[1] = s2; segs[2] = s3; segs[3] = s4;
        for (int j = 0; j < 20; j++) begin
            if (j % 5 < 4) begin
                exp_dig = 4'b0001 << (j / 5);
                exp_seg = segs[j / 5];
            end else begin
                exp_dig = 4'd0;
                exp_seg = 7'd0;
            end
            check($sformatf("%s j%0d frame", tag, j), {15'd0, frame}, {15'd0, j == 0});
            check($sformatf("%s j%0d dig", tag, j), {12'd0, dig4, dig3, dig2, dig1}, {12'd0, exp_dig});
            check($sformatf("%s j%0d seg", tag, j), {9'd0, d7seg}, {9'd0, exp_seg});
            check($sformatf("%s j%0d pend", tag, j), {15'd0, upd_pending}, {15'd0, pend_m});
            if (j == ld_j) begin
                value = lv; mask = lm; load = 1'b1;
            end else if (j == ld2_j) begin
                value = lv2; mask = lm2; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
            // The edge after j=18 ends digit 4 and is the frame boundary.
            apply = (j == 18) && pend_m;
            if (j == ld_j || j == ld2_j) pend_m = 1'b1;
            else if (apply) pend_m = 1'b0;
        end
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset dig", {12'd0, dig4, dig3, dig2, dig1}, 16'd0);
        check("reset seg", {9'd0, d7seg}, 16'd0);
        check("reset frame", {15'd0, frame}, 16'd0);
        check("reset pend", {15'd0, upd_pending}, 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 10; f++)
            check_frame($sformatf("dark%0d", f), 7'h00, 7'h00, 7'h00, 7'h00, -1, 16'd0, 4'd0, -1, 16'd0, 4'd0);

        check_frame("ld8F30", 7'h00, 7'h00, 7'h00, 7'h00, 0, 16'h8F30, 4'b0000, -1, 16'd0, 4'd0);
        check_frame("v8F30", 7'h3F, 7'h4F, 7'h71, 7'h7F, 5, 16'h1234, 4'b1010, -1, 16'd0, 4'd0);
        check_frame("m1234", 7'h66, 7'h00, 7'h5B, 7'h00, 2, 16'h1111, 4'b0000, 10, 16'h2222, 4'b0000);
        check_frame("v2222", 7'h5B, 7'h5B, 7'h5B, 7'h5B, 3, 16'h5555, 4'b0000, 18, 16'h6666, 4'b0000);
        check_frame("v5555", 7'h6D, 7'h6D, 7'h6D, 7'h6D, -1, 16'd0, 4'd0, -1, 16'd0, 4'd0);

        check("pre-rst frame", {15'd0, frame}, 16'd1);
        for (int j = 0; j < 11; j++) begin
            if (j == 5) begin
                value = 16'hFFFF; mask = 4'b0000; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
        check("mid dig3", {12'd0, dig4, dig3, dig2, dig1}, 16'h0004);
        check("mid seg", {9'd0, d7seg}, 16'h007D);
        check("mid pend", {15'd0, upd_pending}, 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst dig", {12'd0, dig4, dig3, dig2, dig1}, 16'd0);
        check("rst seg", {9'd0, d7seg}, 16'd0);
        check("rst pend", {15'd0, upd_pending}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pend_m = 1'b0;
        @(negedge clk);
        check_frame("post0", 7'h00, 7'h00, 7'h00, 7'h00, -1, 16'd0, 4'd0, -1, 16'd0, 4'd0);
        check_frame("post1", 7'h00, 7'h00, 7'h00, 7'h00, -1, 16'd0, 4'd0, -1, 16'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
